// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: states, opcodes,
// ALU-op classes, mux selects and the decoded control bundle.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTEXE   = 4'd6,
    RTWB    = 4'd7,
    BEQEX   = 4'd8,
    BNEEX   = 4'd9,
    JEX     = 4'd10,
    ILLEGAL = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [CTRL_W-1:0] CTRL_RTYPE = 3'b000;
  localparam logic [CTRL_W-1:0] CTRL_LW    = 3'b001;
  localparam logic [CTRL_W-1:0] CTRL_SW    = 3'b010;
  localparam logic [CTRL_W-1:0] CTRL_BEQ   = 3'b011;
  localparam logic [CTRL_W-1:0] CTRL_BNE   = 3'b100;
  localparam logic [CTRL_W-1:0] CTRL_J     = 3'b101;

  localparam logic [SEL_W-1:0] ASB_REG    = 2'b00;
  localparam logic [SEL_W-1:0] ASB_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] ASB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] ASB_IMM_SH = 2'b11;

  localparam logic [SEL_W-1:0] PCS_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCS_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic              pc_write;
    logic              pc_write_cond;
    logic              branch_ne;
    logic              i_or_d;
    logic              mem_read;
    logic              mem_write;
    logic              ir_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              reg_dst;
    logic              alu_src_a;
    logic [SEL_W-1:0]  alu_src_b;
    logic [SEL_W-1:0]  pc_src;
    logic [CTRL_W-1:0] ctrl;
    logic              illegal_op;
  } ctrl_out_t;

  // Idle bundle: every strobe low, ALU class parked on add.
  function automatic ctrl_out_t ctrl_out_idle();
    ctrl_out_t o;
    o      = '0;
    o.ctrl = CTRL_LW;
    return o;
  endfunction

endpackage

// File: rtl/main_control_outdec.sv
// Combinational state-to-control decode for main_control_fsm.
// Optional ILLEGAL-state output is enabled by MAIN_CTRL_ILLEGAL_TRAP_EN.
module main_control_outdec
  import mips_ctrl_pkg::*;
(
  input  logic      rst,
  input  state_e    state,
  input  logic      mem_ready,
  input  logic      is_sw,
  output ctrl_out_t out_c
);

  always_comb begin
    out_c = ctrl_out_idle();
    // Reset overrides the FETCH decode so nothing strobes while held.
    if (!rst) begin
      case (state)
        FETCH: begin
          out_c.mem_read  = 1'b1;
          out_c.alu_src_b = ASB_FOUR;
          out_c.ir_write  = mem_ready;
          out_c.pc_write  = mem_ready;
        end
        DECODE: out_c.alu_src_b = ASB_IMM_SH;
        MEMADR: begin
          out_c.alu_src_a = 1'b1;
          out_c.alu_src_b = ASB_IMM;
          out_c.ctrl      = is_sw ? CTRL_SW : CTRL_LW;
        end
        MEMRD: begin
          out_c.mem_read = 1'b1;
          out_c.i_or_d   = 1'b1;
        end
        MEMWR: begin
          out_c.mem_write = 1'b1;
          out_c.i_or_d    = 1'b1;
        end
        MEMWB: begin
          out_c.reg_write  = 1'b1;
          out_c.mem_to_reg = 1'b1;
        end
        RTEXE: begin
          out_c.alu_src_a = 1'b1;
          out_c.alu_src_b = ASB_REG;
          out_c.ctrl      = CTRL_RTYPE;
        end
        RTWB: begin
          out_c.reg_write = 1'b1;
          out_c.reg_dst   = 1'b1;
        end
        BEQEX, BNEEX: begin
          out_c.alu_src_a     = 1'b1;
          out_c.alu_src_b     = ASB_REG;
          out_c.pc_write_cond = 1'b1;
          out_c.pc_src        = PCS_ALUOUT;
          out_c.ctrl          = (state == BNEEX) ? CTRL_BNE : CTRL_BEQ;
          out_c.branch_ne     = (state == BNEEX);
        end
        JEX: begin
          out_c.ctrl     = CTRL_J;
          out_c.pc_write = 1'b1;
          out_c.pc_src   = PCS_JUMP;
        end
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        ILLEGAL: out_c.illegal_op = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main control: state register and next-state logic.
// Define MAIN_CTRL_ILLEGAL_TRAP_EN to route unknown opcodes through ILLEGAL.
module main_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      opcode,
  input  logic                 mem_ready,
  output logic [CTRL_W-1:0]    ctrl,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 branch_ne,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 alu_src_a,
  output logic [SEL_W-1:0]     alu_src_b,
  output logic [SEL_W-1:0]     pc_src,
  output logic [STATE_W-1:0]   state,
  output logic                 illegal_op
);

  state_e    state_q, state_d;
  logic      is_sw_q, is_sw_d;
  ctrl_out_t out_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  // Next state; the LW/SW class is captured in DECODE for MEMADR's use.
  always_comb begin
    state_d = state_q;
    is_sw_d = is_sw_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        is_sw_d = (opcode == OP_SW);
        case (opcode)
          OP_RTYPE:     state_d = RTEXE;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BEQEX;
          OP_BNE:       state_d = BNEEX;
          OP_J:         state_d = JEX;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = ILLEGAL;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR: state_d = is_sw_q ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWR:  if (mem_ready) state_d = FETCH;
      RTEXE:  state_d = RTWB;
      default: state_d = FETCH;
    endcase
  end

  main_control_outdec u_outdec (
    .rst       (rst),
    .state     (state_q),
    .mem_ready (mem_ready),
    .is_sw     (is_sw_q),
    .out_c     (out_c)
  );

  assign ctrl          = out_c.ctrl;
  assign pc_write      = out_c.pc_write;
  assign pc_write_cond = out_c.pc_write_cond;
  assign branch_ne     = out_c.branch_ne;
  assign i_or_d        = out_c.i_or_d;
  assign mem_read      = out_c.mem_read;
  assign mem_write     = out_c.mem_write;
  assign ir_write      = out_c.ir_write;
  assign mem_to_reg    = out_c.mem_to_reg;
  assign reg_write     = out_c.reg_write;
  assign reg_dst       = out_c.reg_dst;
  assign alu_src_a     = out_c.alu_src_a;
  assign alu_src_b     = out_c.alu_src_b;
  assign pc_src        = out_c.pc_src;
  assign illegal_op    = out_c.illegal_op;
  assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: per-instruction cycle plans expanded from the
// instruction class and memory wait counts, checked cycle by cycle.
module tb_main_control_fsm;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [2:0] ctrl;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  main_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .ctrl(ctrl), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .state(state),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
                ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
                alu_src_b, pc_src, ctrl, illegal_op};

  // Expected control bundle for a state, written straight from the output table.
  function automatic logic [18:0] exp_out(state_e s, logic mr, logic sw, logic r);
    logic pcw = 0, pcwc = 0, bne = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic m2r = 0, rw = 0, rdst = 0, asa = 0, ill = 0;
    logic [1:0] asb = 2'b00, psrc = 2'b00;
    logic [2:0] c = 3'b001;
    if (!r) begin
      case (s)
        FETCH:   begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
        DECODE:  asb = 2'b11;
        MEMADR:  begin asa = 1; asb = 2'b10; c = sw ? 3'b010 : 3'b001; end
        MEMRD:   begin mrd = 1; iord = 1; end
        MEMWR:   begin mwr = 1; iord = 1; end
        MEMWB:   begin rw = 1; m2r = 1; end
        RTEXE:   begin asa = 1; c = 3'b000; end
        RTWB:    begin rw = 1; rdst = 1; end
        BEQEX:   begin asa = 1; c = 3'b011; pcwc = 1; psrc = 2'b01; end
        BNEEX:   begin asa = 1; c = 3'b100; pcwc = 1; bne = 1; psrc = 2'b01; end
        JEX:     begin c = 3'b101; pcw = 1; psrc = 2'b10; end
        ILLEGAL: ill = 1;
        default: ;
      endcase
    end
    return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rdst, asa, asb, psrc, c, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Append a memory-wait phase: w cycles with mem_ready low, then one with it high.
  task automatic add_wait(inout state_e st[$], inout logic mr[$], input state_e s, input int w);
    for (int k = 0; k < w; k++) begin st.push_back(s); mr.push_back(1'b0); end
    st.push_back(s); mr.push_back(1'b1);
  endtask

  task automatic add_one(inout state_e st[$], inout logic mr[$], input state_e s);
    st.push_back(s); mr.push_back(1'($urandom));
  endtask

  // Runs one instruction from FETCH; returns observed write/regwrite/illegal cycle counts.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                           output int n_mw, output int n_rw, output int n_ill);
    state_e plan_st[$];
    logic   plan_mr[$];
    logic   sw;
    sw = (op == OP_SW);
    n_mw = 0; n_rw = 0; n_ill = 0;
    add_wait(plan_st, plan_mr, FETCH, wf);
    add_one(plan_st, plan_mr, DECODE);
    case (op)
      OP_LW:    begin add_one(plan_st, plan_mr, MEMADR); add_wait(plan_st, plan_mr, MEMRD, wm);
                      add_one(plan_st, plan_mr, MEMWB); end
      OP_SW:    begin add_one(plan_st, plan_mr, MEMADR); add_wait(plan_st, plan_mr, MEMWR, wm); end
      OP_RTYPE: begin add_one(plan_st, plan_mr, RTEXE); add_one(plan_st, plan_mr, RTWB); end
      OP_BEQ:   add_one(plan_st, plan_mr, BEQEX);
      OP_BNE:   add_one(plan_st, plan_mr, BNEEX);
      OP_J:     add_one(plan_st, plan_mr, JEX);
      default: begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        add_one(plan_st, plan_mr, ILLEGAL);
`endif
      end
    endcase
    foreach (plan_st[i]) begin
      opcode    = (plan_st[i] == DECODE) ? op : 6'($urandom);
      mem_ready = plan_mr[i];
      @(negedge clk);
      check($sformatf("state op=%b step=%0d", op, i), 32'(state), 32'(plan_st[i]));
      check($sformatf("outputs op=%b st=%0d", op, plan_st[i]), 32'(obs),
            32'(exp_out(plan_st[i], plan_mr[i], sw, 1'b0)));
      if (mem_write)  n_mw++;
      if (reg_write)  n_rw++;
      if (illegal_op) n_ill++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check($sformatf("back_to_fetch op=%b", op), 32'(state), 32'(FETCH));
    @(posedge clk); #1;
  endtask

  // Reset asserted mid-cycle while a memory access is stalled.
  task automatic reset_mid(input logic [5:0] op);
    state_e wst;
    wst = (op == OP_SW) ? MEMWR : MEMRD;
    opcode = op; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    check("pre_reset_state", 32'(state), 32'(wst));
    #2 rst = 1'b1;
    #1;
    check("async_reset_state", 32'(state), 32'(FETCH));
    check("async_reset_outputs", 32'(obs), 32'(exp_out(FETCH, 1'b0, 1'b0, 1'b1)));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_state", 32'(state), 32'(FETCH));
    check("post_reset_no_write", 32'(mem_write), 32'(0));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [5:0] op;
    int wf, wm, exp_mw, exp_rw, exp_ill;
  } vec_t;

  initial begin
    vec_t vecs[9];
    logic [5:0] ops[6];
    int mw, rw, ill, trap;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    trap = 1;
`else
    trap = 0;
`endif
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    vecs[0] = '{OP_LW,     0, 0, 0, 1, 0};
    vecs[1] = '{OP_RTYPE,  0, 0, 0, 1, 0};
    vecs[2] = '{OP_SW,     0, 3, 4, 0, 0};
    vecs[3] = '{OP_BNE,    0, 0, 0, 0, 0};
    vecs[4] = '{OP_J,      0, 0, 0, 0, 0};
    vecs[5] = '{OP_BEQ,    2, 0, 0, 0, 0};
    vecs[6] = '{OP_LW,     1, 2, 0, 1, 0};
    vecs[7] = '{6'b111111, 0, 0, 0, 0, trap};
    vecs[8] = '{6'b001000, 1, 0, 0, 0, trap};

    rst = 1'b1; opcode = 6'b0; mem_ready = 1'b1;
    #2;
    check("reset_state", 32'(state), 32'(FETCH));
    check("reset_outputs", 32'(obs), 32'(exp_out(FETCH, 1'b1, 1'b0, 1'b1)));
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset_held_state", 32'(state), 32'(FETCH));
    check("reset_held_outputs", 32'(obs), 32'(exp_out(FETCH, 1'b1, 1'b0, 1'b1)));
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].wf, vecs[i].wm, mw, rw, ill);
      check($sformatf("vec%0d mem_write_cycles", i), 32'(mw), 32'(vecs[i].exp_mw));
      check($sformatf("vec%0d reg_write_cycles", i), 32'(rw), 32'(vecs[i].exp_rw));
      check($sformatf("vec%0d illegal_cycles", i), 32'(ill), 32'(vecs[i].exp_ill));
    end

    reset_mid(OP_LW);
    reset_mid(OP_SW);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      int pick;
      pick = int'($urandom_range(0, 6));
      op = (pick == 6) ? 6'($urandom) : ops[pick];
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), mw, rw, ill);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL have no parameters; all encodings come from the shared package.
REQ-002 SHALL have port `clk  in  1`: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port `rst  in  1`: asynchronous, active-high reset.
REQ-004 SHALL have port `opcode  in  6`: instruction bits [31:26]; sampled in DECODE only.
REQ-005 SHALL have port `mem_ready  in  1`: memory handshake; the current access completes in the cycle it is 1.
REQ-006 SHALL have port `ctrl  out  3`: ALU-op class for the ALU control stage.
- 000 = R-type (funct-decoded), 001 = LW/add, 010 = SW/add, 011 = BEQ/sub, 100 = BNE/sub, 101 = J.
REQ-007 SHALL have these 1-bit output strobes: pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a.
REQ-008 SHALL have ports `alu_src_b  out  2` (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2) and `pc_src  out  2` (00 ALU result, 01 ALUOut, 10 jump target).
REQ-009 SHALL have ports `state  out  4` (debug view of the state register) and `illegal_op  out  1`.

Function
REQ-010 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, BEQEX, BNEEX, JEX, ILLEGAL.
REQ-011 SHALL make outputs a combinational function of the state register, plus mem_ready where noted; no output register and zero added latency.
REQ-012 SHALL behave as follows in FETCH:
- Drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ctrl=001, pc_src=00.
- Drive ir_write=pc_write=mem_ready.
- Hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-013 SHALL behave as follows in DECODE:
- Drive alu_src_a=0, alu_src_b=11, ctrl=001.
- Go next by opcode: 000000→RTEXE, 100011/101011→MEMADR, 000100→BEQEX, 000101→BNEEX, 000010→JEX, any other→ILLEGAL.
REQ-014 SHALL behave as follows in MEMADR:
- Drive alu_src_a=1, alu_src_b=10.
- Drive ctrl=001 for LW, 010 for SW.
- Go to MEMRD for LW, MEMWR for SW, using an opcode class latched in DECODE.
REQ-015 SHALL behave as follows in MEMRD and MEMWR:
- MEMRD: mem_read=1, i_or_d=1.
- MEMWR: mem_write=1, i_or_d=1.
- Both hold until mem_ready=1; then MEMRD→MEMWB and MEMWR→FETCH.
REQ-016 SHALL behave as follows in MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; then →FETCH.
REQ-017 SHALL behave as follows in RTEXE and RTWB:
- RTEXE: alu_src_a=1, alu_src_b=00, ctrl=000; then →RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0; then →FETCH.
REQ-018 SHALL behave as follows in BEQEX, BNEEX and JEX, each →FETCH:
- BEQEX: alu_src_a=1, alu_src_b=00, ctrl=011, pc_write_cond=1, pc_src=01.
- BNEEX: same as BEQEX but ctrl=100 and branch_ne=1.
- JEX: ctrl=101, pc_write=1, pc_src=10.
REQ-019 SHALL drive every output not listed for a state to 0; the default for ctrl is 001.
REQ-020 SHALL sample mem_ready only in FETCH, MEMRD and MEMWR, ignoring it elsewhere.
REQ-021 SHALL let a mem_ready=1 already present on the first cycle of a wait state complete that access in that same cycle.

Reset
REQ-022 SHALL force state=FETCH immediately when rst=1, independent of clk.
REQ-023 SHALL hold every strobe and illegal_op at 0 while rst=1, with ctrl=001, alu_src_b=00 and pc_src=00.
REQ-024 SHALL abandon any in-flight access on reset mid-operation, with no write strobe asserted afterward; FETCH is entered on the first edge after release.

Configuration
REQ-025 SHALL provide the macro MAIN_CTRL_ILLEGAL_TRAP_EN.
- Defined: ILLEGAL drives illegal_op=1 for exactly one cycle, then →FETCH.
- Undefined: DECODE maps unknown opcodes directly to FETCH, the ILLEGAL state is not implemented, and illegal_op is tied to 0.

Structure
REQ-026 SHALL place in package mips_ctrl_pkg:
- the state enum (4-bit);
- the opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J;
- the ctrl encodings CTRL_RTYPE…CTRL_J.
REQ-027 SHALL split the state-to-output decode into sub-module main_control_outdec (combinational); the next-state logic and state register remain in main_control_fsm.

Verification
REQ-028 SHALL cover LW with opcode=100011 and mem_ready=1 always: state sequence FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; ctrl=001 in MEMADR; reg_write=1 only in MEMWB.
REQ-029 SHALL cover R-type with opcode=000000: ctrl=000 in RTEXE, reg_write=1 with reg_dst=1 in RTWB, back in FETCH after 4 cycles.
REQ-030 SHALL cover SW with opcode=101011 and mem_ready held 0 for 3 cycles in MEMWR: mem_write=1 for 4 cycles, then FETCH.
REQ-031 SHALL cover BNE with opcode=000101: ctrl=100, branch_ne=1 and pc_write_cond=1 for one cycle; and JEX with opcode=000010: pc_write=1, pc_src=10.
REQ-032 SHALL cover rst asserted mid-MEMRD: all strobes drop to 0 asynchronously, and state=FETCH before the next clk edge.
REQ-033 SHALL cover opcode=111111: with the macro defined, illegal_op=1 for one cycle and then FETCH; without it, DECODE goes directly to FETCH and illegal_op stays 0.
